// File: rtl/io_pkg.sv
// Shared types and constants for the board I/O sequencer.
package io_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        WAIT_IN = 2'b01,
        SHOW    = 2'b10,
        ERR     = 2'b11
    } io_state_t;

    localparam logic [31:0]   ERR_CODE          = 32'hDEAD_0000;
    localparam int unsigned   BLINK_DIV_DEFAULT = 12_500_000;
    localparam int unsigned   TIMEOUT_DEFAULT   = 50_000_000;

endpackage

// File: rtl/edge_pulse.sv
// Registered rising-edge detector for a debounced level; one pulse per press.
module edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_pulse_c
);

    logic r_level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= i_level;
        end
    end

    assign o_pulse_c = i_level & ~r_level_q;

endmodule

// File: rtl/io_sequencer.sv
// Handshake FSM between board switches/button/display and the CPU I/O port.
// Optional watchdog into ERR is enabled with `define IOSEQ_WATCHDOG_EN.
module io_sequencer
    import io_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IN_W      = 8,
    parameter int unsigned BLINK_DIV = BLINK_DIV_DEFAULT,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              confirm,
    input  logic [IN_W-1:0]   switch,
    input  logic              cpu_rd_req,
    input  logic              cpu_wr_req,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic [1:0]        state,
    output logic              waiting_led
);

    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    io_state_t           r_state;
    logic                r_stall;
    logic [DATA_W-1:0]   r_rd_data;
    logic [DATA_W-1:0]   r_disp_data;
    logic                r_disp_valid;
    logic                r_led;
    logic [BLINK_W-1:0]  r_blink_cnt;
    logic                w_conf_pulse;
`ifdef IOSEQ_WATCHDOG_EN
    logic [31:0]         r_wd_cnt;
`else
    logic                w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
`endif

    edge_pulse u_confirm_edge (
        .clk       (clk),
        .rst_n     (rst),
        .i_level   (confirm),
        .o_pulse_c (w_conf_pulse)
    );

    // Stall is written alongside every state change so both move on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= RUN;
            r_stall      <= 1'b0;
            r_rd_data    <= '0;
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
            r_led        <= 1'b0;
            r_blink_cnt  <= '0;
`ifdef IOSEQ_WATCHDOG_EN
            r_wd_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                WAIT_IN: begin
                    if (w_conf_pulse) begin
                        r_rd_data   <= DATA_W'(switch);
                        r_state     <= RUN;
                        r_stall     <= 1'b0;
                        r_led       <= 1'b0;
                        r_blink_cnt <= '0;
                    end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                        r_blink_cnt <= '0;
                        r_led       <= ~r_led;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
                    end
                end
                SHOW: begin
                    if (w_conf_pulse) begin
                        r_state <= RUN;
                        r_stall <= 1'b0;
                    end
                end
`ifdef IOSEQ_WATCHDOG_EN
                ERR: begin
                    if (w_conf_pulse) begin
                        r_state  <= RUN;
                        r_stall  <= 1'b0;
                        r_wd_cnt <= '0;
                    end
                end
`endif
                // RUN; without the watchdog ERR is unreachable and behaves as RUN
                default: begin
                    if (cpu_wr_req) begin
                        r_disp_data  <= cpu_wr_data;
                        r_disp_valid <= 1'b1;
                        r_state      <= SHOW;
                        r_stall      <= 1'b1;
`ifdef IOSEQ_WATCHDOG_EN
                        r_wd_cnt     <= '0;
`endif
                    end else if (cpu_rd_req) begin
                        r_state      <= WAIT_IN;
                        r_stall      <= 1'b1;
`ifdef IOSEQ_WATCHDOG_EN
                        r_wd_cnt     <= '0;
`endif
                    end
`ifdef IOSEQ_WATCHDOG_EN
                    else if (r_wd_cnt == 32'(TIMEOUT - 1)) begin
                        r_disp_data  <= DATA_W'(ERR_CODE);
                        r_disp_valid <= 1'b1;
                        r_state      <= ERR;
                        r_stall      <= 1'b1;
                        r_wd_cnt     <= '0;
                    end else begin
                        r_wd_cnt     <= r_wd_cnt + 32'd1;
                    end
`endif
                end
            endcase
        end
    end

    assign state       = r_state;
    assign cpu_stall   = r_stall;
    assign cpu_rd_data = r_rd_data;
    assign disp_data   = r_disp_data;
    assign disp_valid  = r_disp_valid;
    assign waiting_led = r_led;

endmodule

// File: tb/tb_io_sequencer.sv
// Directed bench for io_sequencer with a per-cycle reference model and literal spot checks.
module tb_io_sequencer;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned IN_W      = 8;
    localparam int unsigned BLINK_DIV = 4;
    localparam int unsigned TIMEOUT   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              confirm;
    logic [IN_W-1:0]   switch;
    logic              cpu_rd_req;
    logic              cpu_wr_req;
    logic [DATA_W-1:0] cpu_wr_data;
    logic [DATA_W-1:0] cpu_rd_data;
    logic              cpu_stall;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic [1:0]        state;
    logic              waiting_led;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    io_sequencer #(
        .DATA_W    (DATA_W),
        .IN_W      (IN_W),
        .BLINK_DIV (BLINK_DIV),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .confirm     (confirm),
        .switch      (switch),
        .cpu_rd_req  (cpu_rd_req),
        .cpu_wr_req  (cpu_wr_req),
        .cpu_wr_data (cpu_wr_data),
        .cpu_rd_data (cpu_rd_data),
        .cpu_stall   (cpu_stall),
        .disp_data   (disp_data),
        .disp_valid  (disp_valid),
        .state       (state),
        .waiting_led (waiting_led)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=run 1=waiting for input 2=showing output 3=error
    int          m_mode      = 0;
    logic [31:0] m_rd        = '0;
    logic [31:0] m_disp      = '0;
    bit          m_valid     = 1'b0;
    int          m_wait      = 0;
    int          m_idle      = 0;
    bit          m_conf_prev = 1'b0;
    bit          m_press     = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0; m_rd = '0; m_disp = '0; m_valid = 1'b0;
            m_wait = 0; m_idle = 0; m_conf_prev = 1'b0;
        end else begin
            m_press     = confirm && !m_conf_prev;
            m_conf_prev = confirm;
            case (m_mode)
                0: begin
                    if (cpu_wr_req) begin
                        m_disp = cpu_wr_data; m_valid = 1'b1; m_mode = 2; m_idle = 0;
                    end else if (cpu_rd_req) begin
                        m_mode = 1; m_wait = 0; m_idle = 0;
                    end else begin
                        m_idle++;
`ifdef IOSEQ_WATCHDOG_EN
                        if (m_idle == int'(TIMEOUT)) begin
                            m_mode = 3; m_disp = 32'hDEAD_0000; m_valid = 1'b1; m_idle = 0;
                        end
`endif
                    end
                end
                1: begin
                    if (m_press) begin
                        m_rd = 32'(switch); m_mode = 0;
                    end else begin
                        m_wait++;
                    end
                end
                default: if (m_press) begin m_mode = 0; m_idle = 0; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_state", 32'(state), 32'(m_mode));
            check("model_stall", 32'(cpu_stall), 32'(m_mode != 0));
            check("model_rd_data", cpu_rd_data, m_rd);
            check("model_disp_data", disp_data, m_disp);
            check("model_disp_valid", 32'(disp_valid), 32'(m_valid));
            check("model_led", 32'(waiting_led),
                  (m_mode == 1) ? 32'((m_wait / int'(BLINK_DIV)) % 2) : 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; confirm = 1'b0; switch = '0;
        cpu_rd_req = 1'b0; cpu_wr_req = 1'b0; cpu_wr_data = '0;
        tick(3);
        chk_en = 1'b1;
        #2 rst = 1'b1;
        tick(1);
        check("reset_state", 32'(state), 32'd0);
        check("reset_stall", 32'(cpu_stall), 32'd0);
        check("reset_rd_data", cpu_rd_data, 32'd0);
        check("reset_disp_valid", 32'(disp_valid), 32'd0);
        check("reset_led", 32'(waiting_led), 32'd0);

        // Read with blinking while waiting, long confirm hold
        switch = 8'hA5; cpu_rd_req = 1'b1;
        tick(1);
        cpu_rd_req = 1'b0;
        check("rd_enter_state", 32'(state), 32'd1);
        check("rd_enter_stall", 32'(cpu_stall), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (k == 3)  check("blink_k3", 32'(waiting_led), 32'd0);
            if (k == 4)  check("blink_k4", 32'(waiting_led), 32'd1);
            if (k == 8)  check("blink_k8", 32'(waiting_led), 32'd0);
            if (k == 12) check("blink_k12", 32'(waiting_led), 32'd1);
        end
        check("rd_stall_before_confirm", 32'(cpu_stall), 32'd1);
        confirm = 1'b1;
        tick(1);
        switch = 8'h5A;
        check("rd_exit_state", 32'(state), 32'd0);
        check("rd_exit_stall", 32'(cpu_stall), 32'd0);
        check("rd_data", cpu_rd_data, 32'h0000_00A5);
        check("rd_exit_led", 32'(waiting_led), 32'd0);
        tick(5);
        check("rd_held_state", 32'(state), 32'd0);
        check("rd_data_stable", cpu_rd_data, 32'h0000_00A5);
        confirm = 1'b0;

        // Write and acknowledge
        cpu_wr_data = 32'h1234_5678; cpu_wr_req = 1'b1;
        tick(1);
        cpu_wr_req = 1'b0;
        check("wr_state", 32'(state), 32'd2);
        check("wr_stall", 32'(cpu_stall), 32'd1);
        check("wr_disp_data", disp_data, 32'h1234_5678);
        check("wr_disp_valid", 32'(disp_valid), 32'd1);
        tick(3);
        confirm = 1'b1;
        tick(1);
        confirm = 1'b0;
        check("wr_ack_state", 32'(state), 32'd0);
        check("wr_ack_disp", disp_data, 32'h1234_5678);
        check("wr_ack_valid", 32'(disp_valid), 32'd1);
        tick(1);

        // Simultaneous read and write: write wins
        cpu_rd_req = 1'b1; cpu_wr_req = 1'b1; cpu_wr_data = 32'd7;
        tick(1);
        cpu_rd_req = 1'b0; cpu_wr_req = 1'b0;
        check("sim_state", 32'(state), 32'd2);
        check("sim_disp", disp_data, 32'd7);
        tick(1);
        confirm = 1'b1;
        tick(1);
        confirm = 1'b0;
        check("sim_ack_state", 32'(state), 32'd0);
        tick(2);
        check("sim_no_wait", 32'(state), 32'd0);

        // Reset in the middle of a read
        cpu_rd_req = 1'b1;
        tick(1);
        cpu_rd_req = 1'b0;
        tick(4);
        check("pre_reset_led", 32'(waiting_led), 32'd1);
        #2 rst = 1'b0;
        tick(1);
        check("mid_reset_state", 32'(state), 32'd0);
        check("mid_reset_stall", 32'(cpu_stall), 32'd0);
        check("mid_reset_rd", cpu_rd_data, 32'd0);
        check("mid_reset_disp", disp_data, 32'd0);
        check("mid_reset_valid", 32'(disp_valid), 32'd0);
        check("mid_reset_led", 32'(waiting_led), 32'd0);
        #2 rst = 1'b1;

        // Idle RUN: watchdog fires only when built in
        tick(15);
        check("idle15_state", 32'(state), 32'd0);
        tick(1);
`ifdef IOSEQ_WATCHDOG_EN
        check("wd_state", 32'(state), 32'd3);
        check("wd_disp", disp_data, 32'hDEAD_0000);
        check("wd_stall", 32'(cpu_stall), 32'd1);
        confirm = 1'b1;
        tick(1);
        confirm = 1'b0;
        check("wd_ack_state", 32'(state), 32'd0);
`else
        check("idle16_state", 32'(state), 32'd0);
        tick(30);
        check("idle46_state", 32'(state), 32'd0);
`endif
        tick(2);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
